// File: rtl/lsu_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_e;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int MS_WRITE = 0;
  localparam int MS_READ  = 1;
  localparam int MS_F3_LO = 2;

  // Stores only recognise SB/SH; loads also accept the unsigned byte/half forms.
  function automatic lsu_size_e acc_size(input logic is_write, input logic [2:0] f3);
    lsu_size_e sz;
    sz = SZ_W;
    if (is_write) begin
      case (f3)
        F3_B:    sz = SZ_B;
        F3_H:    sz = SZ_H;
        default: sz = SZ_W;
      endcase
    end else begin
      case (f3)
        F3_B, F3_BU: sz = SZ_B;
        F3_H, F3_HU: sz = SZ_H;
        default:     sz = SZ_W;
      endcase
    end
    return sz;
  endfunction

  function automatic logic is_misaligned(input lsu_size_e sz, input logic [1:0] lo);
    logic m;
    case (sz)
      SZ_H:    m = lo[0];
      SZ_W:    m = (lo != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] store_be(input lsu_size_e sz, input logic [1:0] lo);
    logic [3:0] be;
    case (sz)
      SZ_B:    be = 4'b0001 << lo;
      SZ_H:    be = 4'b0011 << {lo[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_data(input lsu_size_e sz, input logic [31:0] d);
    logic [31:0] r;
    case (sz)
      SZ_B:    r = {4{d[7:0]}};
      SZ_H:    r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// Lane select and sign/zero extension of a 32-bit read word by funct3 and addr[1:0].
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [2:0]  i_f3,
  input  logic [1:0]  i_lo,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[{i_lo, 3'b000} +: 8];
    w_half = i_rdata[{i_lo[1], 4'b0000} +: 16];
    case (i_f3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_data = {24'd0, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_data = {16'd0, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: req/gnt/rvalid data bus master with pipeline stall.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_i,
  input  logic [4:0]    mem_signal_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic          stall_o,
  output logic [DW-1:0] load_data_o,
  output logic          load_valid_o,
  output logic          misalign_o,
  output logic          dmem_req_o,
  output logic          dmem_we_o,
  output logic [AW-1:0] dmem_addr_o,
  output logic [3:0]    dmem_be_o,
  output logic [DW-1:0] dmem_wdata_o,
  input  logic          dmem_gnt_i,
  input  logic          dmem_rvalid_i,
  input  logic [DW-1:0] dmem_rdata_i
);

  lsu_state_e    r_state, w_state_nxt;
  logic          w_write, w_read, w_acc, w_mis;
  logic [2:0]    w_f3;
  lsu_size_e     w_size;
  logic [AW-1:0] w_addr;
  logic [3:0]    w_be;
  logic [DW-1:0] w_wdata;
  logic          w_req, w_stall;
  logic [DW-1:0] w_fmt;

  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [3:0]    r_be;
  logic [DW-1:0] r_wdata;
  logic [2:0]    r_f3;
  logic [1:0]    r_lo;
  logic [DW-1:0] r_load_data;
  logic          r_load_valid;
  logic          r_misalign;

  // A set MemWrite wins over MemRead.
  assign w_write = mem_signal_i[MS_WRITE];
  assign w_read  = mem_signal_i[MS_READ];
  assign w_f3    = mem_signal_i[MS_F3_LO +: 3];
  assign w_acc   = valid_i & (w_write | w_read);
  assign w_size  = acc_size(w_write, w_f3);
  assign w_addr  = {addr_i[AW-1:2], 2'b00};
  assign w_be    = w_write ? store_be(w_size, addr_i[1:0]) : 4'b1111;
  assign w_wdata = store_data(w_size, wdata_i);

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_mis = is_misaligned(w_size, addr_i[1:0]);
`else
  assign w_mis = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_stall     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_acc) begin
          w_stall = 1'b1;
          if (w_mis) begin
            w_state_nxt = DONE;
          end else begin
            w_req = 1'b1;
            if (dmem_gnt_i) w_state_nxt = w_write ? DONE : WAIT;
            else            w_state_nxt = REQ;
          end
        end
      end
      REQ: begin
        w_req   = 1'b1;
        w_stall = 1'b1;
        if (dmem_gnt_i) w_state_nxt = r_we ? DONE : WAIT;
      end
      WAIT: begin
        w_stall = 1'b1;
        if (dmem_rvalid_i) w_state_nxt = DONE;
      end
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    // Reset must drop the bus request and stall even while valid_i is held.
    if (rst) begin
      w_req   = 1'b0;
      w_stall = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_load_valid <= 1'b0;
      r_misalign   <= 1'b0;
      r_load_data  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_load_valid <= (r_state == WAIT) && dmem_rvalid_i;
      r_misalign   <= (r_state == IDLE) && w_acc && w_mis;
      if ((r_state == WAIT) && dmem_rvalid_i) r_load_data <= w_fmt;
    end
  end

  // Access capture: keeps the bus stable through REQ and formats in WAIT.
  always_ff @(posedge clk) begin
    if ((r_state == IDLE) && w_acc) begin
      r_we    <= w_write;
      r_addr  <= w_addr;
      r_be    <= w_be;
      r_wdata <= w_wdata;
      r_f3    <= w_f3;
      r_lo    <= addr_i[1:0];
    end
  end

  lsu_load_align u_align (
    .i_rdata (dmem_rdata_i),
    .i_f3    (r_f3),
    .i_lo    (r_lo),
    .o_data  (w_fmt)
  );

  assign dmem_req_o   = w_req;
  assign stall_o      = w_stall;
  assign dmem_we_o    = (r_state == IDLE) ? w_write : r_we;
  assign dmem_addr_o  = (r_state == IDLE) ? w_addr  : r_addr;
  assign dmem_be_o    = (r_state == IDLE) ? w_be    : r_be;
  assign dmem_wdata_o = (r_state == IDLE) ? w_wdata : r_wdata;
  assign load_data_o  = r_load_data;
  assign load_valid_o = r_load_valid;
  assign misalign_o   = r_misalign;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomized bench for mem_stage_lsu against a transaction-level timeline model.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [4:0]  mem_signal_i;
  logic [31:0] addr_i, wdata_i;
  logic        stall_o, load_valid_o, misalign_o;
  logic [31:0] load_data_o;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] last_ld = 32'd0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .mem_signal_i(mem_signal_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .stall_o(stall_o),
    .load_data_o(load_data_o), .load_valid_o(load_valid_o), .misalign_o(misalign_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Access size in bytes.
  function automatic int msize(input bit wr, input bit [2:0] f3);
    if (wr) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    return (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
  endfunction

  function automatic bit [31:0] m_be(input bit wr, input bit [2:0] f3, input bit [31:0] a);
    int sz = msize(wr, f3);
    if (!wr || sz == 4) return 32'hF;
    if (sz == 2) return a[1] ? 32'hC : 32'h3;
    return 32'd1 << a[1:0];
  endfunction

  function automatic bit [31:0] m_wdata(input bit [2:0] f3, input bit [31:0] w);
    int sz = msize(1'b1, f3);
    if (sz == 1) return {24'd0, w[7:0]} * 32'h01010101;
    if (sz == 2) return {16'd0, w[15:0]} * 32'h00010001;
    return w;
  endfunction

  function automatic bit [31:0] m_load(input bit [2:0] f3, input bit [31:0] a, input bit [31:0] rd);
    int sz = msize(1'b0, f3);
    int off;
    bit [31:0] v;
    if (sz == 4) return rd;
    off = (sz == 2) ? 2 * a[1] : a[1:0];
    v = (rd >> (8 * off)) & ((32'd1 << (8 * sz)) - 1);
    if (f3[2] == 1'b0 && v[8*sz-1]) v = v - (32'd1 << (8 * sz));
    return v;
  endfunction

  function automatic bit m_mis(input bit wr, input bit [2:0] f3, input bit [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
    int sz = msize(wr, f3);
    if (sz == 2) return a[0];
    if (sz == 4) return a[1:0] != 2'b00;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  // One instruction presented in IDLE; g = gnt wait cycles, r = rvalid wait cycles after gnt+1.
  task automatic txn(input bit v, input bit [4:0] ms, input bit [31:0] a, input bit [31:0] wd,
                     input int g, input int r, input bit [31:0] rd);
    bit wr = ms[0];
    bit acc = v && (ms[0] || ms[1]);
    bit [2:0] f3 = ms[4:2];
    bit mis = acc && m_mis(wr, f3, a);
    bit ld = acc && !mis && !wr;
    int total;
    if (!acc) total = 1;
    else if (mis) total = 2;
    else if (wr) total = g + 2;
    else total = g + r + 3;
    for (int k = 0; k < total; k++) begin
      @(negedge clk);
      if (k == 0) begin
        valid_i = v; mem_signal_i = ms; addr_i = a; wdata_i = wd;
      end else begin
        valid_i = 1'($urandom); mem_signal_i = 5'($urandom);
        addr_i = $urandom; wdata_i = $urandom;
      end
      dmem_gnt_i    = acc && !mis && (k == g);
      dmem_rvalid_i = ld && (k == g + 1 + r);
      dmem_rdata_i  = dmem_rvalid_i ? rd : $urandom;
      #1;
      chk("req", dmem_req_o, acc && !mis && k <= g);
      chk("stall", stall_o, acc && k < total - 1);
      chk("load_valid", load_valid_o, ld && k == total - 1);
      chk("misalign", misalign_o, mis && k == total - 1);
      if (ld && k == total - 1) last_ld = m_load(f3, a, rd);
      chk("load_data", load_data_o, last_ld);
      if (acc && !mis && k <= g) begin
        chk("addr", dmem_addr_o, {a[31:2], 2'b00});
        chk("we", dmem_we_o, wr);
        chk("be", dmem_be_o, m_be(wr, f3, a));
        if (wr) chk("wdata", dmem_wdata_o, m_wdata(f3, wd));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    valid_i = 1'b1; mem_signal_i = 5'b01010; addr_i = 32'h100; wdata_i = 32'd0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", dmem_req_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_lv", load_valid_o, 0);
    chk("rst_mis", misalign_o, 0);
    chk("rst_ld", load_data_o, 0);
    @(negedge clk);
    rst = 1'b0; valid_i = 1'b0;

    // Hand-computed anchors for the model.
    chk("pin_sw_be", m_be(1'b1, 3'd2, 32'h100), 32'hF);
    chk("pin_sb_be", m_be(1'b1, 3'd0, 32'h103), 32'h8);
    chk("pin_sb_data", m_wdata(3'd0, 32'h000000A5), 32'hA5A5A5A5);
    chk("pin_lb", m_load(3'd0, 32'h202, 32'h00800000), 32'hFFFFFF80);
    chk("pin_lhu", m_load(3'd5, 32'h302, 32'hBEEF1234), 32'h0000BEEF);
    chk("pin_lh", m_load(3'd1, 32'h302, 32'hBEEF1234), 32'hFFFFBEEF);

    // Directed scenarios.
    txn(1, {3'b010, 2'b01}, 32'h100, 32'hDEADBEEF, 0, 0, 0);
    txn(1, {3'b000, 2'b01}, 32'h103, 32'h000000A5, 0, 0, 0);
    txn(1, {3'b000, 2'b10}, 32'h202, 32'h0, 2, 0, 32'h00800000);
    txn(1, {3'b101, 2'b10}, 32'h302, 32'h0, 0, 0, 32'hBEEF1234);
    txn(1, {3'b001, 2'b10}, 32'h302, 32'h0, 0, 1, 32'hBEEF1234);
    txn(1, {3'b010, 2'b10}, 32'h401, 32'h0, 0, 0, 32'h12345678);
    txn(1, {3'b010, 2'b11}, 32'h402, 32'hCAFEF00D, 1, 0, 0);
    txn(0, {3'b010, 2'b10}, 32'h500, 32'h0, 0, 0, 0);

    // Reset while waiting for read data.
    @(negedge clk);
    valid_i = 1'b1; mem_signal_i = {3'b010, 2'b10}; addr_i = 32'h600;
    dmem_gnt_i = 1'b1; dmem_rvalid_i = 1'b0;
    #1 chk("rw_req0", dmem_req_o, 1);
    @(negedge clk);
    dmem_gnt_i = 1'b0;
    #1 chk("rw_stall_wait", stall_o, 1);
    #1 rst = 1'b1;
    #1;
    chk("rw_req_drop", dmem_req_o, 0);
    chk("rw_stall_drop", stall_o, 0);
    @(negedge clk);
    rst = 1'b0; valid_i = 1'b0;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hFFFFFFFF;
    @(negedge clk);
    dmem_rvalid_i = 1'b0;
    #1;
    chk("rw_late_lv", load_valid_o, 0);
    chk("rw_late_stall", stall_o, 0);
    last_ld = 32'd0;
    txn(1, {3'b100, 2'b10}, 32'h603, 32'h0, 1, 1, 32'h9A000000);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      txn($urandom_range(0, 7) != 0, 5'($urandom), $urandom, $urandom,
          $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

    @(negedge clk);
    valid_i = 1'b0; dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- MEM-stage load/store unit; consumes the EX/MEM pipeline register outputs: address = ALU result, store data = RD2, 5-bit MEM control field.
- Drives a data-memory bus with a req/gnt/rvalid handshake.
- Formats load data with byte/half alignment and sign extension.
- Asserts stall_o to freeze IF..EX/MEM until the access completes.

Parameters:
- AW, 32, address width.
- DW, 32, data width; only 32 is supported.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- valid_i  in  1  MEM stage holds a live instruction
- mem_signal_i  in  5  [0]=MemWrite, [1]=MemRead, [4:2]=funct3
- addr_i  in  AW  byte address (ALU result)
- wdata_i  in  DW  store data (RD2)
- stall_o  out  1  freeze upstream stages and EX/MEM
- load_data_o  out  DW  formatted load result
- load_valid_o  out  1  load_data_o valid this cycle
- misalign_o  out  1  misaligned-access trap pulse
- dmem_req_o  out  1  bus request
- dmem_we_o  out  1  1=write
- dmem_addr_o  out  AW  word-aligned address ({addr[AW-1:2],2'b00})
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  DW  lane-replicated store data
- dmem_gnt_i  in  1  request accepted
- dmem_rvalid_i  in  1  read data valid
- dmem_rdata_i  in  DW  read data

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. On reset, FSM goes to IDLE. All registered outputs are 0: load_data_o, load_valid_o, misalign_o. dmem_req_o and stall_o are also 0.
- Access condition: acc = valid_i & (MemRead | MemWrite). If both bits are set, the access is a write.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE, acc=1:
  - dmem_req_o=1 and stall_o=1, combinational from inputs.
  - dmem_gnt_i=1: write goes to DONE; read goes to WAIT.
  - dmem_gnt_i=0: go to REQ.
- IDLE, acc=0: no request; stall_o=0.
- REQ:
  - req, address, byte enables and data are held stable until gnt; no retraction.
  - stall_o=1. On gnt, write goes to DONE and read goes to WAIT.
- WAIT:
  - stall_o=1.
  - On dmem_rvalid_i, capture formatted data into load_data_o and go to DONE.
  - rvalid arrives no earlier than the cycle after gnt.
- DONE:
  - stall_o=0; load_valid_o=1 for loads; go to IDLE unconditionally.
  - The next instruction arrives in IDLE, so the same access is never re-issued.
- Latency with a zero-wait bus: store 2 cycles (1 stall); load 3 cycles (2 stall). Each gnt wait cycle and each rvalid wait cycle adds 1.
- valid_i and mem_signal_i are sampled only in IDLE; they are ignored in other states.
- Store formatting:
  - SB (funct3 000): be = 0001<<addr[1:0]; data = byte replicated x4.
  - SH (001): be = 0011<<{addr[1],1'b0}; data = half replicated x2.
  - SW (010) and undefined funct3: be=1111, data as-is.
- Load formatting: select lane by addr[1:0].
  - LB (000): sign-extend byte. LBU (100): zero-extend byte.
  - LH (001): sign-extend half. LHU (101): zero-extend half.
  - LW (010) and undefined funct3: full word.
- dmem_we_o=0 for reads; dmem_be_o is don't-care for reads and is driven 1111.
- Reset mid-operation: dmem_req_o drops immediately (asynchronous); any outstanding response is ignored.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- With the macro: misaligned half-word (addr[0]=1) or word (addr[1:0]!=0) access:
  - IDLE issues no request and goes directly to DONE; stall_o=1 for that one cycle.
  - In DONE, misalign_o=1, load_valid_o=0 and load_data_o is unchanged.
- Without the macro: misalign_o is tied 0; low address bits are ignored (half uses addr[1], word uses a word lane) and the access proceeds normally.

Decomposition:
- Package lsu_pkg holds:
  - state enum {IDLE,REQ,WAIT,DONE};
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - MEM field bit indices (MS_WRITE=0, MS_READ=1, MS_F3_LO=2).
- Sub-module lsu_load_align: combinational lane select and sign/zero extension of rdata by funct3 and addr[1:0].

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, gnt same cycle → be=1111, addr=0x100, stall 1 cycle, DONE next.
- SB addr=0x103, wdata=0x000000A5 → be=1000, wdata=0xA5A5A5A5, dmem_addr=0x100.
- LB addr=0x202, rdata=0x0080_0000, gnt delayed 2 cycles, rvalid 1 cycle later → load_data_o=0xFFFFFF80, load_valid_o for 1 cycle, stall 4 cycles.
- LHU addr=0x302, rdata=0xBEEF1234 → 0x0000BEEF; LH on the same data → 0xFFFFBEEF.
- rst asserted in WAIT → req and stall drop in the same cycle; a late rvalid is ignored; next load completes correctly.
- With LSU_MISALIGN_TRAP_EN, LW addr=0x401 → no dmem_req_o, misalign_o pulse, 1 stall cycle. Without the macro → access to 0x400 with be=1111.
